// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cpu_mem_responder_if : core fetch/data ports and byte-loader stream     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          mem_w_en;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_w_data;
    logic [31:0]   mem_r_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic          cpu_run;
    logic [ADDR_W:0] ld_words;

    modport master (
        output pc, mem_w_en, mem_addr, mem_w_data, ld_valid, ld_byte, ld_last,
        input  instr, mem_r_data, ld_ready, cpu_run, ld_words
    );

    modport slave (
        input  pc, mem_w_en, mem_addr, mem_w_data, ld_valid, ld_byte, ld_last,
        output instr, mem_r_data, ld_ready, cpu_run, ld_words
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cpu_mem_responder : shared instr/data word array, filled by byte loader |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cpu_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    cpu_mem_responder_if.slave   bus
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic              cpu_run_r;
    logic [ADDR_W:0]   ld_words_r;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_ptr;
    logic [31:0]       asm_word;

    logic [31:0]       mem [DEPTH];

    logic              ld_accept;
    logic              ld_flush;
    logic              core_we;
    logic [31:0]       merged_word;
    logic [ADDR_W-1:0] pc_idx;
    logic [ADDR_W-1:0] addr_idx;
    logic              unused_addr_bits;

    assign pc_idx   = bus.pc[ADDR_W+1:2];
    assign addr_idx = bus.mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0],
                                bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

    assign ld_accept   = (state == LOAD) && bus.ld_valid;
    // Upper lanes are still zero in asm_word, so a short final word pads with 0.
    assign merged_word = asm_word | (32'(bus.ld_byte) << {byte_cnt, 3'b000});
    assign ld_flush    = ld_accept && ((byte_cnt == 2'd3) || bus.ld_last);
    assign core_we     = (state == RUN) && bus.mem_w_en;

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_flush) begin
            mem[word_ptr] <= merged_word;
        end else if (core_we) begin
            mem[addr_idx] <= bus.mem_w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cpu_run_r  <= 1'b0;
            ld_words_r <= '0;
            byte_cnt   <= 2'd0;
            word_ptr   <= '0;
            asm_word   <= 32'd0;
        end else if (ld_accept) begin
            if (ld_flush) begin
                asm_word <= 32'd0;
                byte_cnt <= 2'd0;
                word_ptr <= word_ptr + 1'b1;
                if (ld_words_r != WORDS_MAX) begin
                    ld_words_r <= ld_words_r + 1'b1;
                end
            end else begin
                asm_word <= merged_word;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (bus.ld_last) begin
                state     <= RUN;
                cpu_run_r <= 1'b1;
            end
        end
    end

    assign bus.ld_ready   = (state == LOAD);
    assign bus.cpu_run    = cpu_run_r;
    assign bus.ld_words   = ld_words_r;
    assign bus.instr      = (state == RUN) ? mem[pc_idx]   : NOP_INSTR;
    assign bus.mem_r_data = (state == RUN) ? mem[addr_idx] : 32'd0;
endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cpu_mem_responder : directed scoreboard bench for cpu_mem_responder  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_cpu_mem_responder;
    localparam int          ADDR_W = 10;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk;
    logic rst_n;

    cpu_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_mem_responder #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    function automatic void expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endfunction

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], last && (i == 3));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic read_data(input logic [31:0] addr);
        bus.mem_addr = addr;
        #1;
    endtask

    logic [7:0] img_b [8];
    logic [7:0] gap_b [5];

    initial begin
        img_b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
        gap_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        rst_n          = 1'b0;
        bus.pc         = 32'd0;
        bus.mem_w_en   = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_w_data = 32'd0;
        bus.ld_valid   = 1'b0;
        bus.ld_byte    = 8'd0;
        bus.ld_last    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        expect_val("rst_cpu_run", 32'd0);
        expect_val("rst_ld_ready", 32'd1);
        expect_val("rst_ld_words", 32'd0);
        expect_val("rst_instr", NOP);
        expect_val("rst_r_data", 32'd0);
        check(32'(bus.cpu_run));
        check(32'(bus.ld_ready));
        check(32'(bus.ld_words));
        check(bus.instr);
        check(bus.mem_r_data);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload five known words so later persistence checks have a reference
        for (int k = 0; k < 5; k++) begin
            send_word(32'hA0A0_0000 | 32'(k), k == 4);
        end
        @(negedge clk);
        expect_val("pre_ld_words", 32'd5);
        expect_val("pre_word4", 32'hA0A0_0004);
        check(32'(bus.ld_words));
        read_data(32'h10);
        check(bus.mem_r_data);

        // Reset from RUN drops cpu_run asynchronously
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_val("arst_cpu_run", 32'd0);
        expect_val("arst_ld_words", 32'd0);
        expect_val("arst_ld_ready", 32'd1);
        check(32'(bus.cpu_run));
        check(32'(bus.ld_words));
        check(32'(bus.ld_ready));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Image load with a core store attempted throughout LOAD
        bus.mem_w_en   = 1'b1;
        bus.mem_addr   = 32'h10;
        bus.mem_w_data = 32'h1234_5678;
        bus.pc         = 32'd4;
        for (int i = 0; i < 7; i++) begin
            send_byte(img_b[i], 1'b0);
        end
        bus.ld_valid = 1'b1;
        bus.ld_byte  = img_b[7];
        bus.ld_last  = 1'b1;
        @(negedge clk);
        expect_val("load_instr_nop", NOP);
        expect_val("load_r_data_zero", 32'd0);
        expect_val("load_cpu_run_low", 32'd0);
        check(bus.instr);
        check(bus.mem_r_data);
        check(32'(bus.cpu_run));
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.mem_w_en = 1'b0;
        expect_val("run_cpu_run_high", 32'd1);
        check(32'(bus.cpu_run));
        @(negedge clk);
        expect_val("img_ld_words", 32'd2);
        expect_val("img_ld_ready", 32'd0);
        expect_val("img_instr_pc4", 32'h0050_0093);
        expect_val("img_word4_kept", 32'hA0A0_0004);
        check(32'(bus.ld_words));
        check(32'(bus.ld_ready));
        check(bus.instr);
        check(bus.mem_r_data);
        bus.pc = 32'd0;
        read_data(32'h8);
        expect_val("img_instr_pc0", 32'h0000_0013);
        expect_val("img_word2_kept", 32'hA0A0_0002);
        check(bus.instr);
        check(bus.mem_r_data);

        // Loader traffic in RUN is ignored
        @(posedge clk); #1;
        bus.ld_valid = 1'b1;
        bus.ld_byte  = 8'hFF;
        bus.ld_last  = 1'b1;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        @(negedge clk);
        expect_val("run_ignore_ld_words", 32'd2);
        expect_val("run_ignore_word0", 32'h0000_0013);
        check(32'(bus.ld_words));
        check(bus.instr);

        // Core stores: read-during-write returns the old word
        @(posedge clk); #1;
        bus.mem_addr   = 32'h100;
        bus.mem_w_data = 32'h1111_1111;
        bus.mem_w_en   = 1'b1;
        @(posedge clk); #1;
        bus.mem_w_data = 32'hDEAD_BEEF;
        bus.pc         = 32'h100;
        @(negedge clk);
        expect_val("rdw_data_old", 32'h1111_1111);
        expect_val("rdw_instr_old", 32'h1111_1111);
        check(bus.mem_r_data);
        check(bus.instr);
        @(posedge clk); #1;
        bus.mem_w_en = 1'b0;
        @(negedge clk);
        expect_val("wr_data_new", 32'hDEAD_BEEF);
        expect_val("wr_instr_new", 32'hDEAD_BEEF);
        expect_val("wr_misaligned", 32'hDEAD_BEEF);
        expect_val("wr_alias", 32'hDEAD_BEEF);
        check(bus.mem_r_data);
        check(bus.instr);
        read_data(32'h103);
        check(bus.mem_r_data);
        read_data(32'h1100);
        check(bus.mem_r_data);

        // Gapped short image: valid low on alternate cycles
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            bus.ld_byte = 8'h5A;
            @(posedge clk); #1;
            send_byte(gap_b[i], i == 4);
        end
        @(negedge clk);
        expect_val("gap_ld_words", 32'd2);
        expect_val("gap_cpu_run", 32'd1);
        expect_val("gap_word0", 32'hDDCC_BBAA);
        expect_val("gap_word1", 32'h0000_00EE);
        expect_val("gap_word2_kept", 32'hA0A0_0002);
        check(32'(bus.ld_words));
        check(32'(bus.cpu_run));
        read_data(32'h0);
        check(bus.mem_r_data);
        read_data(32'h4);
        check(bus.mem_r_data);
        read_data(32'h8);
        check(bus.mem_r_data);

        // Reset mid-load discards the partial word
        pulse_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_val("midld_cpu_run", 32'd0);
        expect_val("midld_ld_words", 32'd0);
        check(32'(bus.cpu_run));
        check(32'(bus.ld_words));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(32'h0403_0201, 1'b1);
        @(negedge clk);
        expect_val("reload_ld_words", 32'd1);
        expect_val("reload_word0", 32'h0403_0201);
        expect_val("reload_word1_kept", 32'h0000_00EE);
        check(32'(bus.ld_words));
        read_data(32'h0);
        check(bus.mem_r_data);
        read_data(32'h4);
        check(bus.mem_r_data);

        // Full-depth plus one: pointer wraps, word count saturates
        pulse_reset();
        for (int k = 0; k <= 1024; k++) begin
            send_word(32'(k), k == 1024);
        end
        @(negedge clk);
        expect_val("wrap_ld_words_sat", 32'd1024);
        expect_val("wrap_word0", 32'd1024);
        expect_val("wrap_word1", 32'd1);
        expect_val("wrap_word1023", 32'd1023);
        check(32'(bus.ld_words));
        read_data(32'h0);
        check(bus.mem_r_data);
        read_data(32'h4);
        check(bus.mem_r_data);
        read_data(32'hFFC);
        check(bus.mem_r_data);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the 5-stage pipelined core: serves the instruction-fetch port (pc -> instr) and the data port (address/write-enable/write-data -> read data) from one shared word array. A byte-stream loader FSM fills the array after reset. The loader then releases the core through cpu_run. Reads are asynchronous, so the core's IF/ID and MEM/WB registers sample data in the same cycle the address is presented. Writes are synchronous.

Parameters:
ADDR_W, 10, word-address width; array depth = 2**ADDR_W words
NOP_INSTR, 32'h0000_0013, instruction driven on instr while core is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
pc  input  32  instruction fetch byte address
instr  output  32  fetched instruction (combinational)
mem_w_en  input  1  data store strobe, one word per cycle
mem_addr  input  32  data byte address
mem_w_data  input  32  store data
mem_r_data  output  32  load data (combinational)
ld_valid  input  1  loader byte valid
ld_ready  output  1  loader byte accepted when valid&ready
ld_byte  input  8  loader byte, little-endian within word
ld_last  input  1  marks final byte of image, qualified by ld_valid
cpu_run  output  1  1 = core released (used as core run/reset-release)
ld_words  output  ADDR_W+1  count of words written by loader

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Addressing: word index = addr[ADDR_W+1:2]. Bits [1:0] are ignored (misaligned access hits the containing word). Upper bits are ignored (aliasing).
- FSM states:
  - LOAD: reset state.
  - RUN: entered on the clock edge that accepts a byte with ld_last=1. Exit only via reset.
- Reset values: state=LOAD, cpu_run=0, ld_ready=1 (combinational from state), ld_words=0, byte_cnt=0, word_ptr=0, assembly register=0. Array contents are NOT cleared by reset.
- LOAD behaviour:
  - ld_ready=1 throughout.
  - Each accepted byte goes into lane byte_cnt of the assembly register; byte_cnt increments mod 4.
  - On the 4th byte, or on any byte with ld_last: the full word (new byte merged in the same cycle, unfilled upper lanes = 0) is written to mem[word_ptr] on that edge. word_ptr then increments mod 2**ADDR_W (wraps, overwriting word 0). ld_words increments, saturating at 2**ADDR_W. Assembly register and byte_cnt clear.
  - ld_last on the edge it is accepted: state goes to RUN and cpu_run=1 from the next cycle.
  - instr = NOP_INSTR and mem_r_data = 0. Core mem_w_en is ignored (no write).
- RUN behaviour:
  - ld_ready=0; ld_valid/ld_byte/ld_last are ignored.
  - instr = mem[pc index]; mem_r_data = mem[mem_addr index], both combinational.
  - mem_w_en=1 writes mem_w_data on the rising edge.
  - Read-during-write, same word: same-cycle reads (data and instruction port) return the old value; the new value is visible the next cycle.
- Latency: reads 0 cycles; writes visible 1 cycle after the strobe edge; cpu_run rises 1 cycle after the ld_last acceptance edge.
- Reset mid-load: partial word discarded, counters to 0, state LOAD. Words already written persist until overwritten by the next load from word 0.
- Reset in RUN: returns to LOAD with cpu_run=0 asynchronously; contents persist.
- Loader write and core write are never simultaneous (exclusive states); no arbitration is needed.

Test Plan:
- Reset, then stream bytes 13 00 00 00 93 00 50 00 with ld_last on the 8th -> mem[0]=0000_0013, mem[1]=0050_0093, ld_words=2, cpu_run=1 one cycle after last byte, instr at pc=4 is 0050_0093.
- Stream AA BB CC DD EE with ld_last on EE -> mem[0]=DDCC_BBAA, mem[1]=0000_00EE, ld_words=2, state RUN.
- Stream ld_valid gaps (valid low alternate cycles) -> same result as back-to-back; bytes are only taken when valid&ready.
- While in LOAD: drive mem_w_en=1, mem_addr=0x10, mem_w_data=1234_5678 -> mem[4] unchanged. Check instr=0000_0013 and mem_r_data=0 throughout LOAD.
- In RUN: write DEAD_BEEF at mem_addr=0x100 -> same-cycle mem_r_data shows old value, next cycle shows DEAD_BEEF. pc=0x100 fetches DEAD_BEEF. Read at mem_addr=0x103 also returns DEAD_BEEF.
- Load 3 bytes, assert rst_n low mid-cycle -> cpu_run=0, ld_words=0 immediately. Reload 4 bytes 01 02 03 04 with ld_last -> mem[0]=0403_0201, and prior mem[1] is unchanged.
